// File: rtl/gol_pkg.sv
// Shared definitions for the generation sequencer: state encoding and
// default timing constants.
package gol_pkg;

  // Clock cycles per generation at the slowest rate (speed 0).
  localparam int unsigned GOL_BASE_DIV = 25_000_000;
  // Width of the period down-counter.
  localparam int unsigned GOL_DIV_W    = 25;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2,
    TICK = 2'd3
  } gen_state_t;

  // True for every state in which the sequencer is doing work.
  function automatic logic state_is_busy(input gen_state_t st);
    return (st != IDLE);
  endfunction

endpackage

// File: rtl/generation_sequencer_input_sync.sv
// Two-flop synchronizer for an asynchronous level, with an optional
// registered rising-edge pulse taken from the synchronized level.
module input_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  assign level = sync_r;

  generate
    if (EDGE) begin : g_edge
      logic prev_r;
      logic rise_r;

      // Edge detect on the stable synchronized level only, never on meta_r.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_r <= 1'b0;
          rise_r <= 1'b0;
        end else begin
          prev_r <= sync_r;
          rise_r <= sync_r & ~prev_r;
        end
      end

      assign rise = rise_r;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/generation_sequencer.sv
// Generation sequencer: paces requests to the grid update engine, either
// free-running at a selectable rate or one generation per button press,
// and emits one gen_tick per completed generation.
module generation_sequencer
  import gol_pkg::*;
#(
  parameter int unsigned BASE_DIV = GOL_BASE_DIV,
  parameter int unsigned DIV_W    = GOL_DIV_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step_btn,
  input  logic [1:0] speed,
  input  logic       step_done,
  output logic       step_req,
  output logic       gen_tick,
  output logic       busy
);

  // One extra bit so that BASE_DIV == 2^DIV_W is representable.
  localparam logic [DIV_W:0]   BASE_EXT = (DIV_W + 1)'(BASE_DIV);
  localparam logic [DIV_W:0]   PER_ZERO = {(DIV_W + 1){1'b0}};
  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W - 1){1'b0}}, 1'b1};

  gen_state_t       state_r;
  gen_state_t       next_state_s;
  logic             load_s;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W:0]   period_s;
  logic [DIV_W-1:0] reload_s;

  logic run_s;
  logic run_rise_unused;
  logic step_level_s;
  logic step_rise_s;

  input_sync #(.EDGE(1'b0)) u_run_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (run),
    .level (run_s),
    .rise  (run_rise_unused)
  );

  input_sync #(.EDGE(1'b1)) u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (step_btn),
    .level (step_level_s),
    .rise  (step_rise_s)
  );

  assign period_s = BASE_EXT >> speed;

  // Reload is period-1, saturating at 0 when the shifted period vanishes.
  always_comb begin
    reload_s = CNT_ZERO;
    if (period_s == PER_ZERO) begin
      reload_s = CNT_ZERO;
    end else begin
      reload_s = period_s[DIV_W-1:0] - CNT_ONE;
    end
  end

  // Next-state decode; speed is only consulted when the counter is loaded.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_s) begin
          next_state_s = WAIT;
          load_s       = 1'b1;
        end else if (step_rise_s) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          next_state_s = REQ;
        end else if (!run_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT;
        end
      end
      REQ: begin
        // A pause never aborts an outstanding request.
        if (step_done) begin
          next_state_s = TICK;
        end else begin
          next_state_s = REQ;
        end
      end
      TICK: begin
        if (run_s) begin
          next_state_s = WAIT;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Period down-counter: loads on entry to WAIT, counts to zero, never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (load_s) begin
      cnt_r <= reload_s;
    end else if ((state_r == WAIT) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Outputs are registered from the next state so they align with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_req <= 1'b0;
      gen_tick <= 1'b0;
      busy     <= 1'b0;
    end else begin
      step_req <= (next_state_s == REQ);
      gen_tick <= (next_state_s == TICK);
      busy     <= state_is_busy(next_state_s);
    end
  end

  // The synchronized button level itself is only needed for edge detection.
  logic step_level_unused;
  assign step_level_unused = step_level_s;

endmodule

// File: doc/generation_sequencer.md
GENERATION_SEQUENCER -- requirements
Module: generation_sequencer

Interface
REQ-001 The block SHALL have parameter BASE_DIV, default 25_000_000, giving clk cycles per generation at speed 0.
REQ-002 The block SHALL have parameter DIV_W, default 25, giving the period counter width; BASE_DIV SHALL be at most 2^DIV_W.
REQ-003 Port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port run  input  1  free-run switch, asynchronous level.
REQ-006 Port step_btn  input  1  single-step button, asynchronous, debounced externally.
REQ-007 Port speed  input  2  rate select; period = BASE_DIV >> speed cycles.
REQ-008 Port step_done  input  1  one-cycle pulse from grid update engine: generation computed.
REQ-009 Port step_req  output  1  level request to grid engine to compute next generation.
REQ-010 Port gen_tick  output  1  one-cycle pulse per completed generation; drives the iteration counter clock/enable.
REQ-011 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 run and step_btn SHALL each pass through a 2-flop synchronizer before use; step_btn SHALL be rising-edge detected after synchronization (one event per press).
REQ-013 FSM states SHALL be IDLE, WAIT, REQ, TICK.
REQ-014 IDLE: run_s high -> WAIT, loading period counter with (BASE_DIV >> speed) - 1; else step edge -> REQ; else stay.
REQ-015 WAIT: counter decrements each cycle; at zero -> REQ; run_s low before zero -> IDLE (no request issued).
REQ-016 REQ: step_req SHALL be 1; step_done high -> TICK; run_s falling SHALL NOT abort a request.
REQ-017 TICK: gen_tick SHALL be 1 for exactly this cycle; next state WAIT (with reload) if run_s high, else IDLE.
REQ-018 step_req and gen_tick SHALL be registered outputs decoded from state; gen_tick rises the cycle after step_done is sampled.
REQ-019 In free run, tick-to-tick spacing SHALL be (BASE_DIV >> speed) + 1 + engine latency cycles (WAIT length plus REQ cycles plus TICK).
REQ-020 speed SHALL be sampled only at counter load; changes mid-WAIT take effect on the next generation.
REQ-021 Step edges while run_s high or state not IDLE SHALL be ignored, not queued.
REQ-022 step_done outside REQ SHALL be ignored.
REQ-023 Simultaneous run_s rise and step edge in IDLE: run takes priority (-> WAIT).
REQ-024 Period counter SHALL never wrap; reload value for speed 3 with BASE_DIV < 8 SHALL saturate at 0 (WAIT lasts one cycle).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, step_req 0, gen_tick 0, busy 0, period counter 0, synchronizer and edge-detect flops 0.
REQ-026 Reset asserted mid-REQ SHALL drop step_req without waiting for step_done; a later stray step_done SHALL be ignored.
REQ-027 After rst_n deasserts, a run held high SHALL reach WAIT no earlier than the third clk edge (synchronizer latency).

Structure
REQ-028 Package gol_pkg SHALL hold the state enumeration and default BASE_DIV/DIV_W constants.
REQ-029 Sub-module input_sync (2-flop synchronizer with optional rising-edge output) SHALL be instantiated for run and step_btn.

Verification (BASE_DIV=16, engine model returns step_done 3 cycles after step_req rises)
REQ-030 Reset mid-REQ: rst_n low while step_req=1 -> step_req 0 same cycle, state IDLE, no gen_tick.
REQ-031 Single step: run=0, one step_btn press -> exactly one step_req, one gen_tick one cycle after step_done; held button gives no second tick.
REQ-032 Free run speed 0: run=1 -> gen_tick period 16+1+3+... constant per REQ-019 over 5 generations; speed 2 -> WAIT of 4 cycles.
REQ-033 Pause during REQ: run drops while step_req=1 -> request completes, gen_tick issued, then IDLE, busy 0.
REQ-034 Ignored inputs: step_btn pulses during free run and stray step_done in IDLE -> no extra step_req or gen_tick.
REQ-035 Speed change mid-WAIT from 0 to 3 -> current WAIT stays 16 cycles, next WAIT 2 cycles.
